// File: rtl/qspi_arb_if.sv
// qspi_arb_if: the two requester ports, the controller handshake and the busy flag of the QSPI arbiter.
// Latency: none; this is a signal bundle.
// Backpressure: requesters hold req until they see their one-cycle completion strobe.
interface qspi_arb_if;
  // port 0: instruction fetch (read only)
  logic        p0_read_req;
  logic        p0_read_w;
  logic        p0_read_hw;
  logic [31:0] p0_read_adr;
  logic        p0_read_valid;
  logic [31:0] p0_read_data;
  // port 1: data load/store
  logic        p1_read_req;
  logic        p1_read_w;
  logic        p1_read_hw;
  logic [31:0] p1_read_adr;
  logic        p1_read_valid;
  logic [31:0] p1_read_data;
  logic        p1_write_req;
  logic        p1_write_w;
  logic        p1_write_hw;
  logic [31:0] p1_write_adr;
  logic [31:0] p1_write_data;
  logic        p1_write_finish;
  // controller side
  logic        read_req;
  logic        write_req;
  logic        read_w;
  logic        read_hw;
  logic        write_w;
  logic        write_hw;
  logic [31:0] read_adr;
  logic [31:0] write_adr;
  logic [31:0] write_data;
  logic        read_valid;
  logic        write_finish;
  logic [31:0] read_data;
  // status
  logic        arb_busy;

  // arbiter view
  modport master (
    input  p0_read_req, p0_read_w, p0_read_hw, p0_read_adr,
    output p0_read_valid, p0_read_data,
    input  p1_read_req, p1_read_w, p1_read_hw, p1_read_adr,
    output p1_read_valid, p1_read_data,
    input  p1_write_req, p1_write_w, p1_write_hw, p1_write_adr, p1_write_data,
    output p1_write_finish,
    output read_req, write_req, read_w, read_hw, write_w, write_hw,
    output read_adr, write_adr, write_data,
    input  read_valid, write_finish, read_data,
    output arb_busy
  );

  // requesters and controller view
  modport slave (
    output p0_read_req, p0_read_w, p0_read_hw, p0_read_adr,
    input  p0_read_valid, p0_read_data,
    output p1_read_req, p1_read_w, p1_read_hw, p1_read_adr,
    input  p1_read_valid, p1_read_data,
    output p1_write_req, p1_write_w, p1_write_hw, p1_write_adr, p1_write_data,
    input  p1_write_finish,
    input  read_req, write_req, read_w, read_hw, write_w, write_hw,
    input  read_adr, write_adr, write_data,
    output read_valid, write_finish, read_data,
    input  arb_busy
  );
endinterface

// File: rtl/qspi_arb.sv
// qspi_arb: grants one of fetch read / data read / data write to the QSPI controller; QSPI_ARB_RR_EN selects port round-robin.
// Latency: request sampled at edge N -> controller pulse in cycle N+1; controller strobe at edge M -> port strobe in cycle M+1.
// Backpressure: one transfer in flight; losing requests stay pending (held by requesters) until the arbiter is back in IDLE.
module qspi_arb (
  input  logic       clk,
  input  logic       rst_n,
  qspi_arb_if.master bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} state_t;
  typedef enum logic [1:0] {G_NONE = 2'd0, G_P0R = 2'd1, G_P1R = 2'd2, G_P1W = 2'd3} grant_t;

  state_t      state_q, state_d;
  grant_t      grant_q, grant_d;
  grant_t      win;
  logic        p1_any;
  logic        grant_rd;
  logic        cpl;

  // issue registers toward the controller and the return data register
  logic        rd_w_q, rd_hw_q;
  logic [31:0] rd_adr_q;
  logic        wr_w_q, wr_hw_q;
  logic [31:0] wr_adr_q, wr_dat_q;
  logic [31:0] ret_q;

  assign p1_any = bus.p1_read_req | bus.p1_write_req;

`ifdef QSPI_ARB_RR_EN
  // set when port 1 was served last; starts as "port 1" so port 0 takes the first tie
  logic last_p1_q;

  // Winner: on port contention the port not served last wins; inside port 1 read beats write.
  always_comb begin
    win = G_NONE;
    if (bus.p0_read_req && p1_any)
      win = last_p1_q ? G_P0R : (bus.p1_read_req ? G_P1R : G_P1W);
    else if (bus.p1_read_req)
      win = G_P1R;
    else if (bus.p1_write_req)
      win = G_P1W;
    else if (bus.p0_read_req)
      win = G_P0R;
  end

  // Last-served flag follows the grant that is handing back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_p1_q <= 1'b1;
    else if (state_q == S_DONE)
      last_p1_q <= (grant_q != G_P0R);
  end
`else
  // Winner: fixed order, data read, then data write, then fetch.
  always_comb begin
    win = G_NONE;
    if (bus.p1_read_req)
      win = G_P1R;
    else if (bus.p1_write_req)
      win = G_P1W;
    else if (bus.p0_read_req)
      win = G_P0R;
  end
`endif

  // Completion is accepted only if its type matches the grant; the state check happens in the FSM.
  assign grant_rd = (grant_q == G_P0R) || (grant_q == G_P1R);
  assign cpl      = grant_rd ? bus.read_valid : ((grant_q == G_P1W) && bus.write_finish);

  // FSM state register: current phase and the grant being served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= G_NONE;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // FSM next state: grant in IDLE, one issue cycle, wait for a matching strobe, one done cycle.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      S_IDLE: begin
        if (win != G_NONE) begin
          state_d = S_ISSUE;
          grant_d = win;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (cpl) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: controller pulses in ISSUE, port strobes in DONE, busy outside IDLE.
  always_comb begin
    bus.read_req        = 1'b0;
    bus.write_req       = 1'b0;
    bus.p0_read_valid   = 1'b0;
    bus.p1_read_valid   = 1'b0;
    bus.p1_write_finish = 1'b0;
    bus.arb_busy        = (state_q != S_IDLE);
    case (state_q)
      S_ISSUE: begin
        bus.read_req  = grant_rd;
        bus.write_req = (grant_q == G_P1W);
      end
      S_DONE: begin
        bus.p0_read_valid   = (grant_q == G_P0R);
        bus.p1_read_valid   = (grant_q == G_P1R);
        bus.p1_write_finish = (grant_q == G_P1W);
      end
      default: ;
    endcase
  end

  // Issue registers load only on a grant, so read_* and write_* each keep their last issued values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_w_q   <= 1'b0;
      rd_hw_q  <= 1'b0;
      rd_adr_q <= 32'h0;
      wr_w_q   <= 1'b0;
      wr_hw_q  <= 1'b0;
      wr_adr_q <= 32'h0;
      wr_dat_q <= 32'h0;
    end else if (state_q == S_IDLE) begin
      case (win)
        G_P0R: begin
          rd_w_q   <= bus.p0_read_w;
          rd_hw_q  <= bus.p0_read_hw;
          rd_adr_q <= bus.p0_read_adr;
        end
        G_P1R: begin
          rd_w_q   <= bus.p1_read_w;
          rd_hw_q  <= bus.p1_read_hw;
          rd_adr_q <= bus.p1_read_adr;
        end
        G_P1W: begin
          wr_w_q   <= bus.p1_write_w;
          wr_hw_q  <= bus.p1_write_hw;
          wr_adr_q <= bus.p1_write_adr;
          wr_dat_q <= bus.p1_write_data;
        end
        default: ;
      endcase
    end
  end

  // Return register captures controller data on the accepted completion; bytes pass through untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ret_q <= 32'h0;
    else if ((state_q == S_WAIT) && cpl)
      ret_q <= bus.read_data;
  end

  assign bus.read_w       = rd_w_q;
  assign bus.read_hw      = rd_hw_q;
  assign bus.read_adr     = rd_adr_q;
  assign bus.write_w      = wr_w_q;
  assign bus.write_hw     = wr_hw_q;
  assign bus.write_adr    = wr_adr_q;
  assign bus.write_data   = wr_dat_q;
  assign bus.p0_read_data = ret_q;
  assign bus.p1_read_data = ret_q;

  // Controller pulses never overlap, and the issue registers stay put while a transfer is outstanding.
  a_req_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.read_req && bus.write_req));
  a_issue_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_WAIT) |=> ($stable(rd_adr_q) && $stable(wr_adr_q) && $stable(wr_dat_q)));

endmodule

// File: tb/tb_qspi_arb.sv
// tb_qspi_arb: table-driven arbitration vectors, hand sequences and randomized traffic against a transaction-level model.
// Latency: controller model answers a configurable number of cycles after each request pulse.
// Backpressure: modelled requesters hold req until their completion strobe.
module tb_qspi_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  qspi_arb_if bus();
  qspi_arb dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef QSPI_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  // requester state (held until completion)
  bit          p0_act, p1r_act, p1w_act, p0_again;
  logic [31:0] p0_adr, p1r_adr, p1w_adr, p1w_dat;
  bit          p0_w, p0_hw, p1r_w, p1r_hw, p1w_w, p1w_hw;

  // controller model
  int          lat = 3;
  int          rd_cnt, wr_cnt;
  bit          ctl_rv, ctl_wf, inj_rv, inj_wf, fix_en;
  logic [31:0] ctl_rdata, fix_data;

  // what was driven for the upcoming edge
  typedef struct {
    bit p0, p1r, p1w, p0w, p0hw, p1rw, p1rhw, p1ww, p1whw, rv, wf;
    logic [31:0] p0a, p1ra, p1wa, p1wd, rd;
  } drv_t;
  drv_t s;

  // transaction-level model: phase 0 idle, 1 issue, 2 wait, 3 done
  int          mph, mg;
  bit          m_last1;
  logic [31:0] m_radr, m_wadr, m_wdat, m_ret;
  bit          m_rw, m_rhw, m_ww, m_whw;
  int          glog[$];
  int          rr_pulses, wr_pulses, n_v0, n_v1, n_f1;
  logic [31:0] last_p0_data;

  function automatic int pick(drv_t d);
    int p1;
    p1 = d.p1r ? 2 : (d.p1w ? 3 : 0);
    if (RR && d.p0 && p1 != 0) return m_last1 ? 1 : p1;
    if (p1 != 0) return p1;
    if (d.p0) return 1;
    return 0;
  endfunction

  task automatic drive();
    bus.p0_read_req   = p0_act;  bus.p0_read_w  = p0_w;  bus.p0_read_hw  = p0_hw;  bus.p0_read_adr = p0_adr;
    bus.p1_read_req   = p1r_act; bus.p1_read_w  = p1r_w; bus.p1_read_hw  = p1r_hw; bus.p1_read_adr = p1r_adr;
    bus.p1_write_req  = p1w_act; bus.p1_write_w = p1w_w; bus.p1_write_hw = p1w_hw;
    bus.p1_write_adr  = p1w_adr; bus.p1_write_data = p1w_dat;
    bus.read_valid    = ctl_rv | inj_rv;
    bus.write_finish  = ctl_wf | inj_wf;
    bus.read_data     = ctl_rdata;
    s = '{p0: p0_act, p1r: p1r_act, p1w: p1w_act, p0w: p0_w, p0hw: p0_hw, p1rw: p1r_w, p1rhw: p1r_hw,
          p1ww: p1w_w, p1whw: p1w_hw, rv: ctl_rv | inj_rv, wf: ctl_wf | inj_wf,
          p0a: p0_adr, p1ra: p1r_adr, p1wa: p1w_adr, p1wd: p1w_dat, rd: ctl_rdata};
  endtask

  task automatic latch(int g);
    if (g == 1) begin m_radr = s.p0a;  m_rw = s.p0w;  m_rhw = s.p0hw; end
    if (g == 2) begin m_radr = s.p1ra; m_rw = s.p1rw; m_rhw = s.p1rhw; end
    if (g == 3) begin m_wadr = s.p1wa; m_wdat = s.p1wd; m_ww = s.p1ww; m_whw = s.p1whw; end
  endtask

  // one clock: drive, move to mid-cycle, advance model, compare, run controller and requesters
  task automatic step();
    int g;
    drive();
    @(negedge clk);
    case (mph)
      0: begin
        g = pick(s);
        if (g != 0) begin mph = 1; mg = g; latch(g); glog.push_back(g); end
      end
      1: mph = 2;
      2: if ((mg != 3 && s.rv) || (mg == 3 && s.wf)) begin mph = 3; m_ret = s.rd; end
      default: begin mph = 0; m_last1 = (mg != 1); end
    endcase
    chk1("read_req", bus.read_req, mph == 1 && mg != 3);
    chk1("write_req", bus.write_req, mph == 1 && mg == 3);
    chk1("arb_busy", bus.arb_busy, mph != 0);
    chk1("p0_read_valid", bus.p0_read_valid, mph == 3 && mg == 1);
    chk1("p1_read_valid", bus.p1_read_valid, mph == 3 && mg == 2);
    chk1("p1_write_finish", bus.p1_write_finish, mph == 3 && mg == 3);
    if (mph == 3 && mg == 1) chk("p0_read_data", bus.p0_read_data, m_ret);
    if (mph == 3 && mg == 2) chk("p1_read_data", bus.p1_read_data, m_ret);
    chk("read_adr", bus.read_adr, m_radr);
    chk1("read_w", bus.read_w, m_rw);
    chk1("read_hw", bus.read_hw, m_rhw);
    chk("write_adr", bus.write_adr, m_wadr);
    chk("write_data", bus.write_data, m_wdat);
    chk1("write_w", bus.write_w, m_ww);
    chk1("write_hw", bus.write_hw, m_whw);
    if (bus.read_req) rr_pulses++;
    if (bus.write_req) wr_pulses++;
    if (bus.p0_read_valid) begin n_v0++; last_p0_data = bus.p0_read_data; end
    if (bus.p1_read_valid) n_v1++;
    if (bus.p1_write_finish) n_f1++;
    // controller: strobe lat cycles after the pulse
    if (rd_cnt > 0) begin rd_cnt--; ctl_rv = (rd_cnt == 0); end else ctl_rv = 1'b0;
    if (wr_cnt > 0) begin wr_cnt--; ctl_wf = (wr_cnt == 0); end else ctl_wf = 1'b0;
    if (bus.read_req) rd_cnt = lat;
    if (bus.write_req) wr_cnt = lat;
    ctl_rdata = (ctl_rv && fix_en) ? fix_data : $urandom;
    // requesters drop on their strobe
    if (mph == 3) begin
      if (mg == 1) begin p0_act = p0_again; p0_again = 0; end
      else if (mg == 2) p1r_act = 0;
      else p1w_act = 0;
    end
    inj_rv = 0;
    inj_wf = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    p0_act = 0; p1r_act = 0; p1w_act = 0; p0_again = 0;
    ctl_rv = 0; ctl_wf = 0; inj_rv = 0; inj_wf = 0; rd_cnt = 0; wr_cnt = 0;
    drive();
    #1;
    chk1("rst p0_read_valid", bus.p0_read_valid, 1'b0);
    chk1("rst p1_read_valid", bus.p1_read_valid, 1'b0);
    chk1("rst p1_write_finish", bus.p1_write_finish, 1'b0);
    chk1("rst read_req", bus.read_req, 1'b0);
    chk1("rst write_req", bus.write_req, 1'b0);
    chk1("rst arb_busy", bus.arb_busy, 1'b0);
    chk("rst p0_read_data", bus.p0_read_data, 32'h0);
    chk("rst p1_read_data", bus.p1_read_data, 32'h0);
    chk("rst read_adr", bus.read_adr, 32'h0);
    chk("rst write_adr", bus.write_adr, 32'h0);
    chk("rst write_data", bus.write_data, 32'h0);
    chk("rst sizes", {28'd0, bus.read_w, bus.read_hw, bus.write_w, bus.write_hw}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mph = 0; mg = 0; m_last1 = 1;
    m_radr = 0; m_wadr = 0; m_wdat = 0; m_ret = 0;
    m_rw = 0; m_rhw = 0; m_ww = 0; m_whw = 0;
  endtask

  task automatic new_p0();
    p0_act = 1; p0_adr = $urandom; p0_w = 1'($urandom_range(0, 1)); p0_hw = 1'($urandom_range(0, 1));
  endtask
  task automatic new_p1r();
    p1r_act = 1; p1r_adr = $urandom; p1r_w = 1'($urandom_range(0, 1)); p1r_hw = 1'($urandom_range(0, 1));
  endtask
  task automatic new_p1w();
    p1w_act = 1; p1w_adr = $urandom; p1w_dat = $urandom;
    p1w_w = 1'($urandom_range(0, 1)); p1w_hw = 1'($urandom_range(0, 1));
  endtask

  // run until no transfer is outstanding or pending; an expired budget is a failure
  task automatic run_quiet(string nm, int budget);
    int n = 0;
    while ((mph != 0 || p0_act || p1r_act || p1w_act) && n < budget) begin
      step();
      n++;
    end
    chk1(nm, n < budget, 1'b1);
  endtask

  typedef struct {
    bit p0, p1r, p1w, again;
    int n;
    bit [5:0] fseq, rseq;
  } vec_t;
  vec_t vt[8];

  initial begin
    bit [5:0] seq;
    int k;
    // {p0, p1r, p1w, p0 re-requests once, grants, fixed order, round-robin order}; 1=P0R 2=P1R 3=P1W
    vt[0] = '{1, 0, 0, 0, 1, 6'b01_00_00, 6'b01_00_00};
    vt[1] = '{0, 1, 0, 0, 1, 6'b10_00_00, 6'b10_00_00};
    vt[2] = '{0, 0, 1, 0, 1, 6'b11_00_00, 6'b11_00_00};
    vt[3] = '{1, 1, 0, 0, 2, 6'b10_01_00, 6'b01_10_00};
    vt[4] = '{1, 0, 1, 0, 2, 6'b11_01_00, 6'b01_11_00};
    vt[5] = '{0, 1, 1, 0, 2, 6'b10_11_00, 6'b10_11_00};
    vt[6] = '{1, 1, 1, 0, 3, 6'b10_11_01, 6'b01_10_11};
    vt[7] = '{1, 1, 0, 1, 3, 6'b10_01_01, 6'b01_10_01};

    #2;
    do_reset();

    for (int i = 0; i < 8; i++) begin
      do_reset();
      lat = 3; fix_en = 0;
      glog.delete();
      if (vt[i].p0) new_p0();
      if (vt[i].p1r) new_p1r();
      if (vt[i].p1w) new_p1w();
      p0_again = vt[i].again;
      run_quiet($sformatf("vec%0d done", i), 200);
      chk($sformatf("vec%0d grants", i), glog.size(), vt[i].n);
      seq = RR ? vt[i].rseq : vt[i].fseq;
      for (int j = 0; j < vt[i].n && j < glog.size(); j++)
        chk($sformatf("vec%0d grant%0d", i, j), glog[j], {30'd0, seq[5 - 2*j -: 2]});
    end

    // single fetch, 20-cycle controller latency
    do_reset();
    rr_pulses = 0; n_v0 = 0; lat = 20; fix_en = 1; fix_data = 32'hDEADBEEF;
    p0_act = 1; p0_adr = 32'h0000_0100; p0_w = 1; p0_hw = 0;
    run_quiet("fetch done", 100);
    chk("fetch read_req pulses", rr_pulses, 1);
    chk("fetch read_adr", bus.read_adr, 32'h0000_0100);
    chk("fetch valids", n_v0, 1);
    chk("fetch data", last_p0_data, 32'hDEADBEEF);
    step();
    chk1("fetch busy after", bus.arb_busy, 1'b0);
    fix_en = 0;

    // halfword data write
    wr_pulses = 0; n_f1 = 0; lat = 5;
    p1w_act = 1; p1w_adr = 32'h0100_0004; p1w_dat = 32'h1234_5678; p1w_w = 0; p1w_hw = 1;
    run_quiet("write done", 100);
    chk("write pulses", wr_pulses, 1);
    chk1("write_hw", bus.write_hw, 1'b1);
    chk("write_data", bus.write_data, 32'h1234_5678);
    chk("write finishes", n_f1, 1);

    // spurious strobes in IDLE and a write strobe during a read wait
    do_reset();
    n_v0 = 0; n_v1 = 0; n_f1 = 0;
    inj_rv = 1; step();
    inj_wf = 1; step();
    step();
    chk("idle strobes", n_v0 + n_v1 + n_f1, 0);
    lat = 10; new_p0();
    k = 0;
    while (mph != 2 && k < 20) begin step(); k++; end
    chk1("spur reach wait", k < 20, 1'b1);
    inj_wf = 1; step();
    chk1("spur still busy", bus.arb_busy, 1'b1);
    run_quiet("spur done", 100);
    chk("spur read completions", n_v0, 1);
    chk("spur write finishes", n_f1, 0);

    // reset while waiting abandons the transfer
    lat = 20; new_p1r();
    k = 0;
    while (mph != 2 && k < 20) begin step(); k++; end
    repeat (3) step();
    do_reset();
    n_v0 = 0; n_v1 = 0; n_f1 = 0;
    repeat (25) step();
    chk("after reset strobes", n_v0 + n_v1 + n_f1, 0);
    lat = 4; new_p1r();
    run_quiet("post reset done", 100);
    chk("post reset completions", n_v1, 1);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      lat = $urandom_range(1, 6);
      if (!p0_act && $urandom_range(0, 3) == 0) new_p0();
      if (!p1r_act && !p1w_act) begin
        k = $urandom_range(0, 7);
        if (k == 0) begin new_p1r(); new_p1w(); end
        else if (k <= 2) new_p1r();
        else if (k <= 4) new_p1w();
      end
      if (mph == 0 && $urandom_range(0, 15) == 0) inj_rv = 1;
      if (mph == 2 && mg == 3 && $urandom_range(0, 7) == 0) inj_rv = 1;
      if (mph == 2 && mg != 3 && $urandom_range(0, 7) == 0) inj_wf = 1;
      step();
    end
    run_quiet("random drain", 300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
